eight_bit_wallace_tree_accumulator: RTL and testbench
=====================================================

// Module: eight_bit_wallace_tree_accumulator
// PURPOSE
//  Downstream consumer of the final Wallace reduction layer. Takes the two surviving 16-bit rows
//  (sum row, carry row) of each 8x8 partial-product tree and resolves them with a registered
//  carry-propagate add (CPA). Accumulates NUM_TERMS products into a wide register (dot-product/MAC
//  use), then presents the total through a valid/ready output handshake.
// PARAMETERS
//  ROW_W       16  width of each reduced row and of the CPA result (8x8 product width)
//  ACC_W       24  accumulator width; must be >= ROW_W
//  NUM_TERMS   16  products summed per accumulation run; 1..255
//  APPROX_BITS 4   LSBs approximated when WALLACE_APPROX_CPA_EN is defined; 0..ROW_W-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      begin a run; honoured only in IDLE
//  in_valid   in   1      row pair valid
//  in_ready   out  1      block can accept a row pair
//  row_s      in   ROW_W  sum row from the final reduction layer
//  row_c      in   ROW_W  carry row from the final reduction layer (already weight-aligned)
//  out_valid  out  1      acc_out holds a completed total
//  out_ready  in   1      consumer takes acc_out
//  acc_out    out  ACC_W  accumulated total
//  overflow   out  1      sticky: accumulator carry-out occurred during this run
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0; out_valid=0; acc_out=0; overflow=0; accept_cnt=0; p1_valid=0.
//  Reset mid-run discards all in-flight data, including a stage-1 term.
//  FSM IDLE -> ACCUM on start (acc_out, overflow and accept_cnt cleared on the same edge).
//      ACCUM -> DONE on the edge where the NUM_TERMS-th term retires from stage 2.
//      DONE -> IDLE on out_valid & out_ready. start outside IDLE is ignored.
//  in_ready = (state==ACCUM) && (accept_cnt != NUM_TERMS). fire = in_valid & in_ready.
//  Stage 1 (edge of fire): cpa_q <= row_s + row_c, truncated to ROW_W (carry-out dropped);
//      p1_valid <= fire; accept_cnt++.
//  Stage 2 (edge with p1_valid): {co, acc_out} <= acc_out + zero-extend(cpa_q);
//      overflow <= overflow | co. acc_out wraps modulo 2^ACC_W.
//  Latency: the final term's fire edge is N; stage 1 registers at N, acc_out updates at N+1,
//      and out_valid=1 from N+1. Full throughput: one term per cycle, no bubbles required.
//  in_valid is ignored while in_ready=0. row_s/row_c are sampled only on fire.
//  out_valid=1 only in DONE; acc_out and overflow hold stable until the handshake completes.
//  Simultaneous out_ready and start in DONE: transition to IDLE only; start is not honoured
//      until the following cycle.
// CONFIGURATION
//  WALLACE_APPROX_CPA_EN defined: CPA bits [APPROX_BITS-1:0] = row_s | row_c, and no carry enters
//      bit APPROX_BITS. Upper bits are an exact add of the upper slices.
//  Undefined: the CPA is an exact ROW_W-bit add. Timing and handshake are identical either way.
// STRUCTURE
//  Package eight_bit_wallace_pkg: ROW_W and ACC_W defaults, state enum {IDLE, ACCUM, DONE}.
//  Sub-module wallace_final_cpa: combinational ROW_W adder that holds the macro-controlled
//      approximate LSB slice; instantiated ahead of the stage-1 register.
//  FSM, counters, pipeline registers and handshakes live in this module.
// TESTING
//  1 Reset while in ACCUM with p1_valid=1 -> all outputs 0 next cycle; next run total excludes
//    the pending term.
//  2 NUM_TERMS=16, each row_s=0xFE01, row_c=0x0000 (255*255) streamed back-to-back
//    -> acc_out=0x0FE010 (1040400), overflow=0, out_valid 1 cycle after the 16th fire.
//  3 Split rows row_s=0x0003, row_c=0x0001 x16: exact build -> acc_out=64;
//    WALLACE_APPROX_CPA_EN with APPROX_BITS=4 -> acc_out=48.
//  4 ACC_W=17, NUM_TERMS=3, rows 0xFFFF/0x0000 -> acc_out=0x0FFFD, overflow=1.
//  5 Random in_valid gaps plus out_ready held low for 5 cycles in DONE -> acc_out and overflow
//    stable, no term lost or duplicated, in_ready=0 throughout DONE.
//  6 start pulsed during ACCUM -> ignored; the 17th in_valid after 16 fires -> not accepted.

Source files
------------

// File: rtl/eight_bit_wallace_tree_accumulator_pkg.sv
// Shared defaults and FSM encoding for the Wallace-tree product accumulator.
package eight_bit_wallace_pkg;

   localparam int ROW_W_DEF = 16;
   localparam int ACC_W_DEF = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/eight_bit_wallace_tree_accumulator_if.sv
// Row-pair input and accumulated-total output handshakes of the Wallace accumulator.
interface eight_bit_wallace_tree_accumulator_if
   import eight_bit_wallace_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int ACC_W = ACC_W_DEF
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [ROW_W-1:0] row_s;
   logic [ROW_W-1:0] row_c;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             overflow;

   modport master (
      output start, in_valid, row_s, row_c, out_ready,
      input  in_ready, out_valid, acc_out, overflow
   );

   modport slave (
      input  start, in_valid, row_s, row_c, out_ready,
      output in_ready, out_valid, acc_out, overflow
   );
endinterface

// File: rtl/eight_bit_wallace_tree_accumulator_cpa.sv
// Combinational final carry-propagate adder for the two reduced Wallace rows.
// WALLACE_APPROX_CPA_EN: the low APPROX_BITS are OR-ed and pass no carry upward.
module wallace_final_cpa #(
   parameter int ROW_W       = 16,
   parameter int APPROX_BITS = 4
) (
   input  logic [ROW_W-1:0] row_s,
   input  logic [ROW_W-1:0] row_c,
   output logic [ROW_W-1:0] sum
);

   generate
      if (APPROX_BITS == 0) begin : g_full
         assign sum = row_s + row_c;
      end else begin : g_split
         localparam int LO = APPROX_BITS;
         localparam int HI = ROW_W - APPROX_BITS;

         logic [LO-1:0] lo;
         logic [HI-1:0] hi;
         logic          lo_co;

`ifdef WALLACE_APPROX_CPA_EN
         assign lo    = row_s[LO-1:0] | row_c[LO-1:0];
         assign lo_co = 1'b0;
`else
         assign {lo_co, lo} = {1'b0, row_s[LO-1:0]} + {1'b0, row_c[LO-1:0]};
`endif

         // Carry-out of the top slice is dropped: the result is a ROW_W-bit product.
         assign hi  = row_s[ROW_W-1:LO] + row_c[ROW_W-1:LO] + HI'(lo_co);
         assign sum = {hi, lo};
      end
   endgenerate

endmodule

// File: rtl/eight_bit_wallace_tree_accumulator.sv
// Resolves Wallace row pairs through a registered CPA and accumulates NUM_TERMS products per run.
// Optional approximate CPA LSBs via WALLACE_APPROX_CPA_EN; one term per cycle, total held until taken.
module eight_bit_wallace_tree_accumulator
   import eight_bit_wallace_pkg::*;
#(
   parameter int ROW_W       = ROW_W_DEF,
   parameter int ACC_W       = ACC_W_DEF,
   parameter int NUM_TERMS   = 16,
   parameter int APPROX_BITS = 4
) (
   input logic                                clk,
   input logic                                rst,
   eight_bit_wallace_tree_accumulator_if.slave bus
);

   localparam int             CNT_W    = 8;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;
   logic [ROW_W-1:0]   cpa_q, cpa_d;
   logic               p1_valid_q, p1_valid_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               overflow_q, overflow_d;

   logic [ROW_W-1:0]   cpa_sum;
   logic [ACC_W:0]     acc_sum;
   logic               in_ready;
   logic               out_valid;
   logic               fire;
   logic               last_retire;

   wallace_final_cpa #(
      .ROW_W       (ROW_W),
      .APPROX_BITS (APPROX_BITS)
   ) u_cpa (
      .row_s (bus.row_s),
      .row_c (bus.row_c),
      .sum   (cpa_sum)
   );

   assign acc_sum     = {1'b0, acc_q} + {{(ACC_W + 1 - ROW_W){1'b0}}, cpa_q};
   // Once the counter saturates, the only term still in stage 1 is the final one.
   assign last_retire = p1_valid_q && (accept_cnt_q == LAST_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start)     state_d = ACCUM;
         ACCUM:   if (last_retire)   state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ACCUM) && (accept_cnt_q != LAST_CNT);
      out_valid = (state_q == DONE);
      fire      = bus.in_valid && in_ready;
   end

   always_comb begin
      accept_cnt_d = accept_cnt_q;
      cpa_d        = cpa_q;
      p1_valid_d   = fire;
      acc_d        = acc_q;
      overflow_d   = overflow_q;
      if ((state_q == IDLE) && bus.start) begin
         accept_cnt_d = '0;
         acc_d        = '0;
         overflow_d   = 1'b0;
      end else begin
         if (fire) begin
            cpa_d        = cpa_sum;
            accept_cnt_d = accept_cnt_q + CNT_W'(1);
         end
         if (p1_valid_q) begin
            acc_d      = acc_sum[ACC_W-1:0];
            overflow_d = overflow_q | acc_sum[ACC_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accept_cnt_q <= '0;
         cpa_q        <= '0;
         p1_valid_q   <= 1'b0;
         acc_q        <= '0;
         overflow_q   <= 1'b0;
      end else begin
         accept_cnt_q <= accept_cnt_d;
         cpa_q        <= cpa_d;
         p1_valid_q   <= p1_valid_d;
         acc_q        <= acc_d;
         overflow_q   <= overflow_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.acc_out   = acc_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_eight_bit_wallace_tree_accumulator.sv
// Bench: constant-row runs from a vector table, reset/overflow corner sequences, random-gap runs.
module tb_eight_bit_wallace_tree_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   eight_bit_wallace_tree_accumulator_if #(.ROW_W(16), .ACC_W(24)) if0 ();
   eight_bit_wallace_tree_accumulator_if #(.ROW_W(16), .ACC_W(17)) if1 ();

   eight_bit_wallace_tree_accumulator #(
      .ROW_W(16), .ACC_W(24), .NUM_TERMS(16), .APPROX_BITS(4)
   ) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   eight_bit_wallace_tree_accumulator #(
      .ROW_W(16), .ACC_W(17), .NUM_TERMS(3), .APPROX_BITS(4)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   typedef struct {
      string       name;
      logic [15:0] s;
      logic [15:0] c;
      logic [23:0] exp_acc;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[5];

   // Product the final adder should deliver for one row pair.
   function automatic logic [15:0] cpa_ref(input logic [15:0] s, input logic [15:0] c);
      int unsigned si = s;
      int unsigned ci = c;
`ifdef WALLACE_APPROX_CPA_EN
      int unsigned hi = ((si / 16) + (ci / 16)) % 4096;
      return 16'((hi * 16) + ((si | ci) % 16));
`else
      return 16'((si + ci) % 65536);
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", n, act, exp);
      end
   endtask

   task automatic run_const(input string n, input logic [15:0] s, input logic [15:0] c,
                            input logic [23:0] exp_acc, input logic exp_ovf);
      int fires = 0;
      int guard = 0;
      bit will;
      if0.start = 1'b1;
      step();
      if0.start = 1'b0;
      check({n, "_rdy"}, {31'd0, if0.in_ready}, 32'd1);
      while (fires < 16 && guard < 200) begin
         if0.in_valid = 1'b1;
         if0.row_s    = s;
         if0.row_c    = c;
         if0.start    = (fires == 5);
         will         = if0.in_ready;
         step();
         guard++;
         if (will) fires++;
      end
      if0.start = 1'b0;
      check({n, "_fires"}, fires, 32'd16);
      // A 17th term is offered right after the last fire; it must be refused.
      if0.row_s = 16'hFFFF;
      if0.row_c = 16'hFFFF;
      check({n, "_full_rdy"}, {31'd0, if0.in_ready}, 32'd0);
      check({n, "_ov_early"}, {31'd0, if0.out_valid}, 32'd0);
      step();
      if0.in_valid = 1'b0;
      check({n, "_ov"}, {31'd0, if0.out_valid}, 32'd1);
      check({n, "_acc"}, {8'd0, if0.acc_out}, {8'd0, exp_acc});
      check({n, "_ovf"}, {31'd0, if0.overflow}, {31'd0, exp_ovf});
      if0.out_ready = 1'b1;
      step();
      if0.out_ready = 1'b0;
      check({n, "_idle"}, {31'd0, if0.out_valid}, 32'd0);
   endtask

   task automatic run_random(input int r);
      int          cnt = 0;
      int          guard = 0;
      longint      exp = 0;
      logic [15:0] rs, rc;
      logic [23:0] exp_acc;
      bit          iv;
      if0.start = 1'b1;
      step();
      if0.start = 1'b0;
      while (cnt < 16 && guard < 400) begin
         iv = ($urandom_range(0, 2) != 0);
         rs = 16'($urandom);
         rc = 16'($urandom);
         if0.in_valid = iv;
         if0.row_s    = rs;
         if0.row_c    = rc;
         check($sformatf("rnd%0d_rdy", r), {31'd0, if0.in_ready}, 32'd1);
         if (iv) begin
            exp += longint'(cpa_ref(rs, rc));
            cnt++;
         end
         step();
         guard++;
      end
      check($sformatf("rnd%0d_cnt", r), cnt, 32'd16);
      check($sformatf("rnd%0d_ov_early", r), {31'd0, if0.out_valid}, 32'd0);
      if0.in_valid = 1'b1;
      step();
      exp_acc = 24'(exp % 64'd16777216);
      for (int k = 0; k < 5; k++) begin
         if0.row_s = 16'($urandom);
         if0.row_c = 16'($urandom);
         check($sformatf("rnd%0d_hold_ov", r), {31'd0, if0.out_valid}, 32'd1);
         check($sformatf("rnd%0d_hold_acc", r), {8'd0, if0.acc_out}, {8'd0, exp_acc});
         check($sformatf("rnd%0d_hold_ovf", r), {31'd0, if0.overflow},
               (exp >= 64'd16777216) ? 32'd1 : 32'd0);
         check($sformatf("rnd%0d_hold_rdy", r), {31'd0, if0.in_ready}, 32'd0);
         step();
      end
      if0.in_valid  = 1'b0;
      if0.out_ready = 1'b1;
      step();
      if0.out_ready = 1'b0;
      check($sformatf("rnd%0d_idle", r), {31'd0, if0.out_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"sq255", 16'hFE01, 16'h0000, 24'h0FE010, 1'b0};
      vecs[1] = '{"zero",  16'h0000, 16'h0000, 24'h000000, 1'b0};
      vecs[2] = '{"mix",   16'h1230, 16'h4560, 24'h057900, 1'b0};
      vecs[3] = '{"wrap",  16'h8000, 16'h8000, 24'h000000, 1'b0};
`ifdef WALLACE_APPROX_CPA_EN
      vecs[4] = '{"split", 16'h0003, 16'h0001, 24'd48, 1'b0};
`else
      vecs[4] = '{"split", 16'h0003, 16'h0001, 24'd64, 1'b0};
`endif

      {if0.start, if0.in_valid, if0.out_ready} = 3'b000;
      {if1.start, if1.in_valid, if1.out_ready} = 3'b000;
      if0.row_s = '0; if0.row_c = '0;
      if1.row_s = '0; if1.row_c = '0;
      rst = 1'b1;
      step();
      step();
      check("rst_rdy",  {31'd0, if0.in_ready},  32'd0);
      check("rst_ov",   {31'd0, if0.out_valid}, 32'd0);
      check("rst_acc",  {8'd0, if0.acc_out},    32'd0);
      check("rst_ovf",  {31'd0, if0.overflow},  32'd0);
      check("rst1_ov",  {31'd0, if1.out_valid}, 32'd0);
      check("rst1_acc", {15'd0, if1.acc_out},   32'd0);
      rst = 1'b0;
      step();

      // Reset in the middle of a run while a term sits in stage 1.
      if0.start = 1'b1;
      step();
      if0.start    = 1'b0;
      if0.in_valid = 1'b1;
      if0.row_s    = 16'hFFFF;
      if0.row_c    = 16'h0000;
      step();
      step();
      step();
      if0.in_valid = 1'b0;
      check("mid_acc_nz", {31'd0, (if0.acc_out != 24'd0)}, 32'd1);
      rst = 1'b1;
      step();
      check("mid_rst_rdy", {31'd0, if0.in_ready},  32'd0);
      check("mid_rst_ov",  {31'd0, if0.out_valid}, 32'd0);
      check("mid_rst_acc", {8'd0, if0.acc_out},    32'd0);
      check("mid_rst_ovf", {31'd0, if0.overflow},  32'd0);
      rst = 1'b0;
      step();
      run_const("post_rst", 16'hFE01, 16'h0000, 24'h0FE010, 1'b0);

      for (int i = 0; i < 5; i++) begin
         run_const(vecs[i].name, vecs[i].s, vecs[i].c, vecs[i].exp_acc, vecs[i].exp_ovf);
      end

      // Narrow accumulator: three 0xFFFF products wrap 17 bits.
      if1.start = 1'b1;
      step();
      if1.start    = 1'b0;
      if1.in_valid = 1'b1;
      if1.row_s    = 16'hFFFF;
      if1.row_c    = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         check("ovf_rdy", {31'd0, if1.in_ready}, 32'd1);
         step();
      end
      if1.in_valid = 1'b0;
      check("ovf_ov_early", {31'd0, if1.out_valid}, 32'd0);
      step();
      check("ovf_ov",  {31'd0, if1.out_valid}, 32'd1);
      check("ovf_acc", {15'd0, if1.acc_out},   32'h0FFFD);
      check("ovf_bit", {31'd0, if1.overflow},  32'd1);
      if1.out_ready = 1'b1;
      step();
      if1.out_ready = 1'b0;
      check("ovf_idle", {31'd0, if1.out_valid}, 32'd0);

      for (int r = 0; r < 3; r++) begin
         run_random(r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
